// File: rtl/rv_mdu_seq.sv
// rv_mdu_seq - sequential RV32M/RV64M multiply/divide unit for the EX stage.
//
// Takes one operation per valid/ready handshake. Multiplies use radix-2
// shift-add and divides use restoring division, one bit per cycle. The
// result comes back with the rd tag the operation brought in.
//
// Parameters:
//   XLEN  - operand/result width (32 or 64)
//   TAG_W - width of the rd tag carried alongside the op
//
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   IN_VALID / IN_READY  op request / unit idle and able to accept
//   IN_FUNCT             0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   IN_RS1, IN_RS2       operands (dividend/multiplicand, divisor/multiplier)
//   IN_TAG               rd tag, returned unchanged on OUT_TAG
//   KILL                 flush: abandon any in-flight or held op
//   OUT_VALID/OUT_READY  result handshake
//   OUT_RESULT, OUT_TAG  registered result and its tag
//   BUSY                 unit is not idle
//
// Optional build macro:
//   MDU_FAST_SPECIAL_EN - rs2==0, rs1==0 and signed-overflow divides bypass
//   the iterative datapath and report their result one edge after acceptance.
//   Results are bit-identical with or without it.

module rv_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       IN_FUNCT,
  input  logic [XLEN-1:0]  IN_RS1,
  input  logic [XLEN-1:0]  IN_RS2,
  input  logic [TAG_W-1:0] IN_TAG,
  input  logic             KILL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_RESULT,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN);

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_REM    = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2:0]          funct_q, funct_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;

  // Operand signedness and magnitudes. Operands are registered raw at
  // acceptance; the first CALC cycle turns them into magnitudes so the
  // negation stays off the input path.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_signed = (funct_q == F_MULH) || (funct_q == F_MULHSU) ||
                    (funct_q == F_DIV)  || (funct_q == F_REM);
  assign b_signed = (funct_q == F_MULH) || (funct_q == F_DIV) || (funct_q == F_REM);
  assign a_neg    = a_signed && a_q[XLEN-1];
  assign b_neg    = b_signed && b_q[XLEN-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;

  // Multiply step: acc = {partial product, remaining multiplier bits};
  // b_q holds the multiplicand magnitude.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide step: acc = {partial remainder, quotient/dividend bits};
  // b_q holds the divisor magnitude. A zero divisor naturally yields an
  // all-ones quotient and the dividend as remainder.
  logic [XLEN:0]     div_top, div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_top  = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_top - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Sign correction and hi/lo select. The zero-divisor quotient must stay
  // all ones regardless of the dividend sign, so it skips negation.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_result;

  assign prod_fix = neg_q ? -acc_q : acc_q;

  always_comb begin
    fix_result = '0;
    if (!funct_q[2]) begin
      fix_result = (funct_q == F_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else if (funct_q[1]) begin
      fix_result = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end else if (b_q == '0) begin
      fix_result = '1;
    end else begin
      fix_result = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end
  end

`ifdef MDU_FAST_SPECIAL_EN
  // Special operands, evaluated on the raw registered operands during the
  // first CALC cycle.
  logic            rs1_zero, rs2_zero, sgn_ovf, special_hit;
  logic [XLEN-1:0] special_result;

  assign rs1_zero    = (a_q == '0);
  assign rs2_zero    = (b_q == '0);
  assign sgn_ovf     = ((funct_q == F_DIV) || (funct_q == F_REM)) &&
                       (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign special_hit = rs1_zero || rs2_zero || sgn_ovf;

  always_comb begin
    special_result = '0;
    if (rs2_zero) begin
      if (funct_q[2]) special_result = funct_q[1] ? a_q : '1;
    end else if (!rs1_zero && sgn_ovf && !funct_q[1]) begin
      special_result = a_q;
    end
  end
`endif

  // Next-state and datapath control. KILL is applied last so it overrides
  // everything, including a same-cycle acceptance.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    funct_d      = funct_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          funct_d = IN_FUNCT;
          a_d     = IN_RS1;
          b_d     = IN_RS2;
          tag_d   = IN_TAG;
          count_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == '0) begin
          if (funct_q[2]) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            b_d   = b_mag;
            neg_d = funct_q[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            acc_d = {{XLEN{1'b0}}, b_mag};
            b_d   = a_mag;
            neg_d = a_neg ^ b_neg;
          end
`ifdef MDU_FAST_SPECIAL_EN
          if (special_hit) begin
            out_result_d = special_result;
            out_tag_d    = tag_q;
            out_valid_d  = 1'b1;
            state_d      = ST_DONE;
          end
`endif
        end else begin
          acc_d = funct_q[2] ? div_next : mul_next;
          if (count_q == LAST_STEP) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        out_result_d = fix_result;
        out_tag_d    = tag_q;
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (KILL) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      funct_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      funct_q      <= funct_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign IN_READY   = (state_q == ST_IDLE) && !RST;
  assign BUSY       = (state_q != ST_IDLE);
  assign OUT_VALID  = out_valid_q;
  assign OUT_RESULT = out_result_q;
  assign OUT_TAG    = out_tag_q;

endmodule

// File: tb/tb_rv_mdu_seq.sv
// Directed testbench for rv_mdu_seq (XLEN=32, TAG_W=5).
module tb_rv_mdu_seq;

  logic        CLK, RST, IN_VALID, IN_READY, KILL, OUT_VALID, OUT_READY, BUSY;
  logic [2:0]  IN_FUNCT;
  logic [31:0] IN_RS1, IN_RS2, OUT_RESULT;
  logic [4:0]  IN_TAG, OUT_TAG;

  int errors = 0;
  int checks = 0;

  localparam int NORMAL_LAT = 34;
`ifdef MDU_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  rv_mdu_seq #(.XLEN(32), .TAG_W(5)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_FUNCT(IN_FUNCT), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_TAG(IN_TAG),
    .KILL(KILL), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RESULT(OUT_RESULT), .OUT_TAG(OUT_TAG), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Issues one op (caller is #1 after a rising edge, OUT_READY high), scrambles
  // the inputs after acceptance, waits for OUT_VALID and samples one edge later.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic [31:0] res, output logic [4:0] tg,
                        output int lat, output logic vld_after);
    IN_FUNCT = f; IN_RS1 = a; IN_RS2 = b; IN_TAG = t; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_FUNCT = ~f; IN_RS1 = ~a; IN_RS2 = ~b; IN_TAG = ~t;
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1) begin lat = e; break; end
    end
    res = OUT_RESULT; tg = OUT_TAG;
    @(posedge CLK); #1;
    vld_after = OUT_VALID;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; KILL = 1'b0; OUT_READY = 1'b1;
    IN_FUNCT = 3'd0; IN_RS1 = 32'd0; IN_RS2 = 32'd0; IN_TAG = 5'd0;
    repeat (3) @(posedge CLK); #1;
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    checks++; if (OUT_RESULT !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_result: got %h want 0", OUT_RESULT); end
    checks++; if (OUT_TAG !== 5'd0) begin errors++; $display("[TB] FAIL reset_out_tag: got %h want 0", OUT_TAG); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", BUSY); end
    RST = 1'b0; #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", IN_READY); end
    @(posedge CLK); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  f [12];
    logic [31:0] a [12];
    logic [31:0] b [12];
    logic [31:0] x [12];
    int          lx [12];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic        va;
    f = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd2, 3'd0, 3'd3, 3'd1, 3'd1, 3'd0, 3'd2, 3'd0};
    a = '{32'd8, 32'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
          32'h80000000, 32'h80000000, 32'hFFFFFFFE, 32'd0, 32'd2, 32'hFFFFFFFF};
    b = '{32'd8, 32'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h10,
          32'd4, 32'h80000000, 32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
    x = '{32'h40, 32'h0, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h23456780,
          32'h2, 32'h40000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h1};
    lx = '{NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, NORMAL_LAT,
           NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, SPECIAL_LAT, NORMAL_LAT, NORMAL_LAT};
    for (int i = 0; i < 12; i++) begin
      run_op(f[i], a[i], b[i], 5'(i + 3), res, tg, lat, va);
      checks++; if (res !== x[i]) begin errors++; $display("[TB] FAIL mul%0d_result: got %h want %h", i, res, x[i]); end
      checks++; if (tg !== 5'(i + 3)) begin errors++; $display("[TB] FAIL mul%0d_tag: got %0d want %0d", i, tg, i + 3); end
      checks++; if (lat != lx[i]) begin errors++; $display("[TB] FAIL mul%0d_latency: got %0d want %0d", i, lat, lx[i]); end
      checks++; if (va !== 1'b0) begin errors++; $display("[TB] FAIL mul%0d_pulse: got %b want 0", i, va); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f [16];
    logic [31:0] a [16];
    logic [31:0] b [16];
    logic [31:0] x [16];
    int          lx [16];
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic        va;
    f = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6,
          3'd4, 3'd6, 3'd5, 3'd7, 3'd6, 3'd4, 3'd5, 3'd4};
    a = '{32'd20, 32'd20, 32'hFFFFFFEC, 32'hFFFFFFEC, 32'd7, 32'd7, 32'h80000000, 32'h80000000,
          32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFFFFFF, 32'd0};
    b = '{32'd15, 32'd15, 32'd15, 32'd15, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'd0, 32'd0, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'd5};
    x = '{32'd1, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0,
          32'hFFFFFFFF, 32'hFFFFFFF9, 32'd14, 32'd2, 32'd1, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'd0};
    lx = '{NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, SPECIAL_LAT, SPECIAL_LAT,
           SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, SPECIAL_LAT, NORMAL_LAT, NORMAL_LAT,
           NORMAL_LAT, NORMAL_LAT, NORMAL_LAT, SPECIAL_LAT};
    for (int i = 0; i < 16; i++) begin
      run_op(f[i], a[i], b[i], 5'(i + 10), res, tg, lat, va);
      checks++; if (res !== x[i]) begin errors++; $display("[TB] FAIL div%0d_result: got %h want %h", i, res, x[i]); end
      checks++; if (tg !== 5'(i + 10)) begin errors++; $display("[TB] FAIL div%0d_tag: got %0d want %0d", i, tg, i + 10); end
      checks++; if (lat != lx[i]) begin errors++; $display("[TB] FAIL div%0d_latency: got %0d want %0d", i, lat, lx[i]); end
      checks++; if (va !== 1'b0) begin errors++; $display("[TB] FAIL div%0d_pulse: got %b want 0", i, va); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    lat = -1;
    OUT_READY = 1'b0;
    IN_FUNCT = 3'd5; IN_RS1 = 32'd100; IN_RS2 = 32'd7; IN_TAG = 5'd12; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1) begin lat = e; break; end
    end
    checks++; if (lat != NORMAL_LAT) begin errors++; $display("[TB] FAIL bp_latency: got %0d want %0d", lat, NORMAL_LAT); end
    IN_VALID = 1'b1; IN_FUNCT = 3'd0; IN_RS1 = 32'd3; IN_RS2 = 32'd3; IN_TAG = 5'd1;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_RESULT !== 32'd14 || OUT_TAG !== 5'd12 || IN_READY !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b result=%h tag=%0d in_ready=%b want 1/0000000e/12/0",
                 c, OUT_VALID, OUT_RESULT, OUT_TAG, IN_READY);
      end
    end
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b in_ready=%b busy=%b want 0/1/0", OUT_VALID, IN_READY, BUSY);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_kill();
    int lat;
    lat = -1;
    IN_FUNCT = 3'd5; IN_RS1 = 32'hFFFFFFFF; IN_RS2 = 32'd3; IN_TAG = 5'd2; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (4) @(posedge CLK); #1;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL kill_busy_before: got %b want 1", BUSY); end
    KILL = 1'b1; IN_VALID = 1'b1; IN_FUNCT = 3'd0; IN_RS1 = 32'd3; IN_RS2 = 32'd4; IN_TAG = 5'd7;
    @(posedge CLK); #1;
    checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_flush: got in_ready=%b busy=%b valid=%b want 1/0/0", IN_READY, BUSY, OUT_VALID);
    end
    KILL = 1'b0;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || IN_READY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL kill_reaccept: got busy=%b in_ready=%b want 1/0", BUSY, IN_READY);
    end
    for (int e = 1; e <= 100; e++) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1) begin lat = e; break; end
    end
    checks++; if (lat != NORMAL_LAT) begin errors++; $display("[TB] FAIL kill_latency: got %0d want %0d", lat, NORMAL_LAT); end
    checks++; if (OUT_RESULT !== 32'd12) begin errors++; $display("[TB] FAIL kill_result: got %h want 0000000c", OUT_RESULT); end
    checks++; if (OUT_TAG !== 5'd7) begin errors++; $display("[TB] FAIL kill_tag: got %0d want 7", OUT_TAG); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic        va;
    run_op(3'd0, 32'd3, 32'd5, 5'd1, res, tg, lat, va);
    checks++; if (res !== 32'd15) begin errors++; $display("[TB] FAIL b2b_first_result: got %h want 0000000f", res); end
    checks++; if (va !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_pulse: got %b want 0", va); end
    run_op(3'd5, 32'd50, 32'd6, 5'd2, res, tg, lat, va);
    checks++; if (res !== 32'd8) begin errors++; $display("[TB] FAIL b2b_second_result: got %h want 00000008", res); end
    checks++; if (tg !== 5'd2) begin errors++; $display("[TB] FAIL b2b_second_tag: got %0d want 2", tg); end
    checks++; if (lat != NORMAL_LAT) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d want %0d", lat, NORMAL_LAT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    logic        va;
    run_op(3'd0, 32'd8, 32'd8, 5'd3, res, tg, lat, va);
    IN_FUNCT = 3'd5; IN_RS1 = 32'd100; IN_RS2 = 32'd7; IN_TAG = 5'd9; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b want 1", BUSY); end
    RST = 1'b1; #1;
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_RESULT !== 32'd0 || OUT_TAG !== 5'd0 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_clear: got valid=%b result=%h tag=%0d busy=%b want all 0",
               OUT_VALID, OUT_RESULT, OUT_TAG, BUSY);
    end
    @(posedge CLK); #1;
    RST = 1'b0; #1;
    checks++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_idle: got in_ready=%b busy=%b want 1/0", IN_READY, BUSY);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
